// File: rtl/tpsram_stream_reader.sv
// Read-side ring-buffer controller for the two-port sample SRAM: issues reads, absorbs the
// 1-cycle RAM latency in a 2-entry skid buffer and emits a framed valid/ready word stream.
module tpsram_stream_reader #(
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 32,
  parameter int FRAME_WORDS = 64
) (
  input  logic              RCLK,
  input  logic              RST,
  input  logic              EN,
  input  logic [ADDR_W:0]   WPTR,
  output logic [ADDR_W:0]   RPTR,
  output logic [ADDR_W-1:0] RADDR,
  input  logic [DATA_W-1:0] RD,
  output logic [DATA_W-1:0] DOUT,
  output logic              DOUT_VALID,
  input  logic              DOUT_READY,
  output logic              DOUT_LAST,
  output logic [ADDR_W:0]   LEVEL,
  output logic              BUSY
);

  localparam int FW_W = (FRAME_WORDS > 2) ? $clog2(FRAME_WORDS) : 1;
  localparam logic [FW_W-1:0] LAST_IDX = FW_W'(FRAME_WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W:0]   iptr;
  logic [ADDR_W:0]   avail;
  logic [FW_W-1:0]   frame_cnt;
  logic              issue;
  logic              pop;
  logic [2:0]        occ;
  logic              vld_p1;
  logic              last_p1;
  logic              skid_vld_p2;
  logic              skid_we;
  logic [DATA_W-1:0] skid_data_p2;
  logic              skid_last_p2;

  assign pop   = DOUT_VALID & DOUT_READY;
  assign avail = WPTR - iptr;
  assign occ   = {2'b00, vld_p1} + {2'b00, DOUT_VALID} + {2'b00, skid_vld_p2} - {2'b00, pop};
  assign RADDR = iptr[ADDR_W-1:0];
  assign BUSY  = (state != IDLE);

  // Leaving RUN at a frame boundary must not issue, or the next frame would start and be cut short.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      IDLE:  if (EN) state_nxt = RUN;
      RUN: begin
        if (!EN && frame_cnt == '0) state_nxt = DRAIN;
        else if (avail != '0 && occ < 3'd2) issue = 1'b1;
      end
      DRAIN: if (!vld_p1 && !DOUT_VALID && !skid_vld_p2 && !pop) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // p0: issue stage -- pointers, frame position, FSM
  always_ff @(posedge RCLK) begin
    if (RST) begin
      state     <= IDLE;
      iptr      <= '0;
      frame_cnt <= '0;
      vld_p1    <= 1'b0;
      last_p1   <= 1'b0;
      RPTR      <= '0;
      LEVEL     <= '0;
    end else begin
      state  <= state_nxt;
      vld_p1 <= issue;
      LEVEL  <= avail;
      if (issue) begin
        iptr      <= iptr + 1'b1;
        last_p1   <= (frame_cnt == LAST_IDX);
        frame_cnt <= (frame_cnt == LAST_IDX) ? '0 : frame_cnt + 1'b1;
      end
      if (vld_p1) RPTR <= RPTR + 1'b1;
    end
  end

  // p1: capture RD into the output head register or the second skid entry
  always_ff @(posedge RCLK) begin
    if (RST) begin
      DOUT        <= '0;
      DOUT_LAST   <= 1'b0;
      DOUT_VALID  <= 1'b0;
      skid_vld_p2 <= 1'b0;
    end else if (pop) begin
      if (skid_vld_p2) begin
        DOUT        <= skid_data_p2;
        DOUT_LAST   <= skid_last_p2;
        skid_vld_p2 <= vld_p1;
      end else if (vld_p1) begin
        DOUT      <= RD;
        DOUT_LAST <= last_p1;
      end else begin
        DOUT_VALID <= 1'b0;
      end
    end else if (vld_p1) begin
      if (!DOUT_VALID) begin
        DOUT       <= RD;
        DOUT_LAST  <= last_p1;
        DOUT_VALID <= 1'b1;
      end else begin
        skid_vld_p2 <= 1'b1;
      end
    end
  end

  assign skid_we = vld_p1 & ((pop & skid_vld_p2) | (~pop & DOUT_VALID));

  // p2: second skid entry payload, data only
  always_ff @(posedge RCLK) begin
    if (skid_we) begin
      skid_data_p2 <= RD;
      skid_last_p2 <= last_p1;
    end
  end

endmodule

// File: tb/tb_tpsram_stream_reader.sv
// Bench for tpsram_stream_reader: RAM + writer model, random ready/write pacing, and a
// stream scoreboard indexed by absolute word number since reset.
module tb_tpsram_stream_reader;
  localparam int AW = 9;
  localparam int DW = 32;
  localparam int FW = 64;

  logic          RCLK = 1'b0;
  logic          RST = 1'b1;
  logic          EN = 1'b0;
  logic [AW:0]   WPTR = '0;
  logic [AW:0]   RPTR;
  logic [AW-1:0] RADDR;
  logic [DW-1:0] RD = '0;
  logic [DW-1:0] DOUT;
  logic          DOUT_VALID;
  logic          DOUT_READY = 1'b0;
  logic          DOUT_LAST;
  logic [AW:0]   LEVEL;
  logic          BUSY;

  tpsram_stream_reader #(.ADDR_W(AW), .DATA_W(DW), .FRAME_WORDS(FW)) dut (
    .RCLK(RCLK), .RST(RST), .EN(EN), .WPTR(WPTR), .RPTR(RPTR), .RADDR(RADDR), .RD(RD),
    .DOUT(DOUT), .DOUT_VALID(DOUT_VALID), .DOUT_READY(DOUT_READY), .DOUT_LAST(DOUT_LAST),
    .LEVEL(LEVEL), .BUSY(BUSY)
  );

  always #5 RCLK = ~RCLK;

  logic [DW-1:0] mem [512];
  logic [DW-1:0] wdata [1024];
  int widx = 0;
  int wr_target = 0;
  int wr_rate = 100;
  bit wr_seq = 1'b0;
  int ready_mode = 1;
  int exp_idx = 0;
  int cyc = 0;
  int first_pop_cyc = 0;
  int last_pop_cyc = 0;
  int pass_cnt = 0;
  int check_cnt = 0;
  logic [DW-1:0] last_words [$];

  always @(posedge RCLK) RD <= mem[RADDR];

  task automatic chk(input string name, input longint act, input longint exp);
    check_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // writer: fills the ring, never past a full buffer relative to RPTR
  initial begin
    int room;
    forever begin
      @(posedge RCLK); #1;
      room = 512 - ((int'(WPTR) - int'(RPTR)) & 1023);
      if (RST) begin
        WPTR = '0;
        widx = 0;
      end else if (widx < wr_target && room > 0 && $urandom_range(99) < wr_rate) begin
        wdata[widx] = wr_seq ? DW'(widx) : $urandom;
        mem[WPTR[AW-1:0]] = wdata[widx];
        widx++;
        WPTR = WPTR + 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(posedge RCLK); #1;
      DOUT_READY = (ready_mode == 2) ? 1'($urandom_range(1)) : (ready_mode == 1);
    end
  end

  // stream scoreboard: every popped word must be the next written word, LAST on frame ends
  initial begin
    bit prev_stall = 1'b0;
    logic [DW-1:0] prev_dout = '0;
    logic prev_last = 1'b0;
    int lead;
    forever begin
      @(negedge RCLK);
      cyc++;
      if (RST) begin
        exp_idx = 0;
        prev_stall = 1'b0;
        last_words.delete();
      end else begin
        if (prev_stall) begin
          chk("stall_valid", DOUT_VALID, 1);
          chk("stall_dout", DOUT, prev_dout);
          chk("stall_last", DOUT_LAST, prev_last);
        end
        lead = (int'(RPTR) - exp_idx) & 1023;
        chk("rptr_lead_le2", lead <= 2, 1);
        if (DOUT_VALID && DOUT_READY) begin
          if (exp_idx >= widx || exp_idx >= 1024) begin
            chk("word_not_written", exp_idx, widx - 1);
          end else begin
            chk("dout_data", DOUT, wdata[exp_idx]);
            chk("dout_last", DOUT_LAST, (exp_idx % FW) == FW - 1);
          end
          if (DOUT_LAST) last_words.push_back(DOUT);
          if (exp_idx == 0) first_pop_cyc = cyc;
          last_pop_cyc = cyc;
          exp_idx++;
        end
        prev_stall = DOUT_VALID && !DOUT_READY;
        prev_dout = DOUT;
        prev_last = DOUT_LAST;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge RCLK); #1; end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    EN = 1'b0;
    wr_target = 0;
    tick(3);
    RST = 1'b0;
  endtask

  task automatic wait_written(input int n);
    int c = 0;
    while (widx < n && c < 2000) begin tick(1); c++; end
    chk("preload_done", widx >= n, 1);
  endtask

  task automatic wait_pops(input int n, input int budget);
    int c = 0;
    while (exp_idx < n && c < budget) begin @(negedge RCLK); c++; end
    chk("pops_reached", exp_idx >= n, 1);
    @(posedge RCLK); #1;
  endtask

  task automatic wait_idle();
    int c = 0;
    while (BUSY && c < 500) begin tick(1); c++; end
    chk("busy_drops", BUSY, 0);
  endtask

  initial begin
    logic [AW-1:0] seq [$];
    logic [AW-1:0] prev_addr;
    int c;

    // 1: reset state and empty buffer
    do_reset();
    @(negedge RCLK);
    chk("rst_rptr", RPTR, 0);
    chk("rst_raddr", RADDR, 0);
    chk("rst_dout", DOUT, 0);
    chk("rst_valid", DOUT_VALID, 0);
    chk("rst_last", DOUT_LAST, 0);
    chk("rst_level", LEVEL, 0);
    chk("rst_busy", BUSY, 0);
    @(posedge RCLK); #1;
    EN = 1'b1;
    tick(10);
    @(negedge RCLK);
    chk("empty_raddr", RADDR, 0);
    chk("empty_valid", DOUT_VALID, 0);
    chk("empty_rptr", RPTR, 0);
    chk("empty_busy", BUSY, 1);
    @(posedge RCLK); #1;
    EN = 1'b0;
    wait_idle();

    // 2: 128 preloaded sequential words at full rate
    do_reset();
    wr_seq = 1'b1; wr_rate = 100; ready_mode = 1; wr_target = 128;
    wait_written(128);
    EN = 1'b1;
    wait_pops(128, 1000);
    tick(5);
    chk("t2_count", exp_idx, 128);
    chk("t2_back_to_back", last_pop_cyc - first_pop_cyc, 127);
    chk("t2_last_count", last_words.size(), 2);
    if (last_words.size() == 2) begin
      chk("t2_last_word0", last_words[0], 63);
      chk("t2_last_word1", last_words[1], 127);
    end
    chk("t2_rptr", RPTR, 128);
    chk("t2_level", LEVEL, 0);
    chk("t2_raddr", RADDR, 128);
    EN = 1'b0;
    wait_idle();

    // 3: random backpressure, then random write pacing with underflow gaps
    do_reset();
    wr_seq = 1'b0; wr_target = 128;
    wait_written(128);
    ready_mode = 2; EN = 1'b1;
    wait_pops(128, 3000);
    tick(5);
    chk("t3_count", exp_idx, 128);
    chk("t3_rptr", RPTR, 128);
    EN = 1'b0;
    wait_idle();
    do_reset();
    wr_rate = 30; wr_target = 256; EN = 1'b1;
    wait_pops(256, 6000);
    EN = 1'b0;
    wait_idle();
    chk("t3u_count", exp_idx, 256);
    chk("t3u_rptr", RPTR, 256);
    wr_rate = 100; ready_mode = 1;

    // 4: address wrap from 511 to 0
    do_reset();
    wr_target = 500; EN = 1'b1;
    wait_pops(500, 2000);
    tick(5);
    chk("t4_raddr_500", RADDR, 500);
    chk("t4_rptr_500", RPTR, 500);
    prev_addr = RADDR;
    wr_target = 530;
    c = 0;
    while ((exp_idx < 530 || int'(RPTR) != 530) && c < 500) begin
      tick(1);
      if (RADDR != prev_addr) seq.push_back(RADDR);
      prev_addr = RADDR;
      c++;
    end
    chk("t4_seq_len", seq.size(), 30);
    if (seq.size() == 30) begin
      chk("t4_seq_511", seq[10], 511);
      chk("t4_seq_0", seq[11], 0);
      chk("t4_seq_18", seq[29], 18);
    end
    chk("t4_rptr", RPTR, 530);
    chk("t4_rptr_msb", RPTR[AW], 1);
    chk("t4_count", exp_idx, 530);

    // 5: EN drops mid-frame, frame completes, then reader stops
    do_reset();
    wr_target = 200;
    wait_written(200);
    EN = 1'b1;
    wait_pops(20, 200);
    EN = 1'b0;
    wait_idle();
    tick(20);
    chk("t5_count", exp_idx, 64);
    chk("t5_raddr", RADDR, 64);
    chk("t5_rptr", RPTR, 64);
    chk("t5_level", LEVEL, 136);
    chk("t5_busy", BUSY, 0);

    // 6: reset while stalled with data pending
    do_reset();
    wr_target = 20;
    wait_written(20);
    EN = 1'b1;
    wait_pops(10, 200);
    ready_mode = 0;
    tick(3);
    RST = 1'b1;
    @(posedge RCLK);
    @(negedge RCLK);
    chk("t6_valid", DOUT_VALID, 0);
    chk("t6_rptr", RPTR, 0);
    chk("t6_raddr", RADDR, 0);
    chk("t6_busy", BUSY, 0);
    chk("t6_dout", DOUT, 0);
    @(posedge RCLK); #1;
    RST = 1'b0;
    EN = 1'b0;
    ready_mode = 1;
    tick(3);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end
endmodule
